// File: rtl/calc_pkg.sv
// Shared encodings for the shared-calculator scheduler: op codes, FSM states, default width.
package calc_pkg;

  localparam int CALC_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } calc_state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational WIDTH-bit add/sub/mul/div; results wrap mod 2^WIDTH, divide by zero gives 0 + dz.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_dz
);

  always_comb begin
    o_result = '0;
    o_dz     = 1'b0;
    case (i_op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_MUL: o_result = i_a * i_b;
      OP_DIV: begin
        if (i_b == '0) o_dz = 1'b1;
        else           o_result = i_a / i_b;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/calc_rr_scheduler.sv
// Round-robin arbiter + IDLE/EXEC/DONE sequencer sharing one calc_alu between two requesters.
module calc_rr_scheduler
  import calc_pkg::*;
#(
  parameter int WIDTH       = CALC_W,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req0,
  input  logic [1:0]       i_op0,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_req1,
  input  logic [1:0]       i_op1,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_rvalid0,
  output logic             o_rvalid1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_dz,
  output logic             o_busy,
  output logic             o_owner
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  calc_state_t      r_state;
  calc_state_t      w_state_nxt;
  logic             r_last;
  logic             r_owner;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_ack;
  logic [1:0]       r_rvalid;
  logic [WIDTH-1:0] r_result;
  logic             r_dz;
  logic             r_busy;

  logic             w_grant;
  logic             w_win;
  logic             w_capture;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_dz;

  // On contention the requester that did not win last time gets the slot.
  assign w_win     = (i_req0 & i_req1) ? ~r_last : i_req1;
  assign w_grant   = (r_state == ST_IDLE) & (i_req0 | i_req1);
  assign w_capture = (r_state == ST_EXEC) & (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)   w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_capture) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Grant bookkeeping and operand latch; the ALU sees only these regs during EXEC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_ack   <= 2'b00;
    end else begin
      r_ack <= 2'b00;
      if (w_grant) begin
        r_last       <= w_win;
        r_owner      <= w_win;
        r_op         <= w_win ? i_op1 : i_op0;
        r_a          <= w_win ? i_a1  : i_a0;
        r_b          <= w_win ? i_b1  : i_b0;
        r_cnt        <= CW'(EXEC_CYCLES - 1);
        r_ack[w_win] <= 1'b1;
      end else if ((r_state == ST_EXEC) && !w_capture) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_result <= '0;
      r_dz     <= 1'b0;
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= 2'b00;
      if (w_capture) begin
        r_result          <= w_alu_res;
        r_dz              <= w_alu_dz;
        r_rvalid[r_owner] <= 1'b1;
      end
    end
  end

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_res),
    .o_dz     (w_alu_dz)
  );

  assign o_ack0    = r_ack[0];
  assign o_ack1    = r_ack[1];
  assign o_rvalid0 = r_rvalid[0];
  assign o_rvalid1 = r_rvalid[1];
  assign o_result  = r_result;
  assign o_dz      = r_dz;
  assign o_busy    = r_busy;
  assign o_owner   = r_owner;

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// Directed + random bench for calc_rr_scheduler against a slot/time-window reference model.
module tb_calc_rr_scheduler;

  localparam int W  = 4;
  localparam int EC = 2;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_req0 = 1'b0, i_req1 = 1'b0;
  logic [1:0]   i_op0 = '0, i_op1 = '0;
  logic [W-1:0] i_a0 = '0, i_b0 = '0, i_a1 = '0, i_b1 = '0;
  logic         o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_dz, o_busy, o_owner;
  logic [W-1:0] o_result;

  calc_rr_scheduler #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req0(i_req0), .i_op0(i_op0), .i_a0(i_a0), .i_b0(i_b0),
    .i_req1(i_req1), .i_op1(i_op1), .i_a1(i_a1), .i_b1(i_b1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_result(o_result), .o_dz(o_dz), .o_busy(o_busy), .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a grant at sample edge k occupies the calculator until edge k+EC+2;
  // ack follows edge k, rvalid follows edge k+EC, busy covers edges k..k+EC.
  int       cyc = 0, next_free = 0, busy_until = -1, done_edge = 0, ngrant = 0;
  bit       m_last = 1'b1, m_owner = 1'b0, pend = 1'b0, pend_who = 1'b0;
  bit       ea0, ea1, er0, er1;
  logic [W-1:0] pend_res, hold_res = '0;
  bit       pend_dz, hold_dz = 1'b0;
  int       ack_log[$];

  function automatic logic [4:0] ref_alu(input logic [1:0] op, input int a, input int b);
    int r; bit dz;
    r = 0; dz = 0;
    case (op)
      2'd0: r = (a + b) % 16;
      2'd1: r = (a - b + 16) % 16;
      2'd2: r = (a * b) % 16;
      default: if (b == 0) dz = 1; else r = a / b;
    endcase
    return {dz, r[3:0]};
  endfunction

  task automatic step();
    logic [4:0] ra;
    bit w;
    @(posedge i_clk);
    ea0 = 0; ea1 = 0; er0 = 0; er1 = 0;
    if (!i_reset_n) begin
      m_last = 1; m_owner = 0; next_free = 0; busy_until = -1; pend = 0;
      hold_res = '0; hold_dz = 0;
    end else begin
      if (pend && cyc == done_edge) begin
        er0 = !pend_who; er1 = pend_who; pend = 0;
        hold_res = pend_res; hold_dz = pend_dz;
      end
      if (cyc >= next_free && (i_req0 || i_req1)) begin
        w = (i_req0 && i_req1) ? !m_last : i_req1;
        m_last = w; m_owner = w; pend = 1; pend_who = w;
        ra = w ? ref_alu(i_op1, int'(i_a1), int'(i_b1)) : ref_alu(i_op0, int'(i_a0), int'(i_b0));
        pend_res = ra[3:0]; pend_dz = ra[4];
        done_edge = cyc + EC; busy_until = cyc + EC; next_free = cyc + EC + 2;
        ea0 = !w; ea1 = w; ngrant++;
      end
    end
    #1;
    chk("ctl", {26'd0, o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_busy, o_owner},
        {26'd0, ea0, ea1, er0, er1, (cyc <= busy_until), m_owner});
    chk("result", {27'd0, o_dz, o_result}, {27'd0, hold_dz, hold_res});
    if (o_ack0) ack_log.push_back(0);
    if (o_ack1) ack_log.push_back(1);
    cyc++;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    chk("rst_out", {24'd0, o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_busy, o_owner, o_dz, |o_result}, 32'd0);
    step(); step();
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // Raise one request, wait (bounded) for its ack, drop it, then run to its rvalid.
  task automatic one_op(input bit who, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int waited);
    waited = 0;
    if (who) begin i_req1 = 1; i_op1 = op; i_a1 = a; i_b1 = b; end
    else     begin i_req0 = 1; i_op0 = op; i_a0 = a; i_b0 = b; end
    do begin step(); waited++; end while (!(who ? o_ack1 : o_ack0) && waited < 10);
    chk("op_ack_seen", {31'd0, (who ? o_ack1 : o_ack0)}, 32'd1);
    i_req0 = 0; i_req1 = 0;
    repeat (EC) step();
    chk("op_rvalid", {30'd0, o_rvalid1, o_rvalid0}, who ? 32'd2 : 32'd1);
  endtask

  initial begin
    int waited, guard, g0;
    // 1: reset and idle
    do_reset();
    repeat (20) step();
    chk("t1_idle_busy", {31'd0, o_busy}, 32'd0);

    // 2: single add 9+8 -> 1
    one_op(0, 2'b00, 4'd9, 4'd8, waited);
    chk("t2_ack_latency", waited, 32'd1);
    chk("t2_result", {27'd0, o_dz, o_result}, 32'd1);
    repeat (3) step();

    // 3: contention from reset, order 0,1,0,1, req0 operands churn after ack
    i_req0 = 1; i_op0 = 2'b00; i_a0 = 4'd2; i_b0 = 4'd3;
    i_req1 = 1; i_op1 = 2'b11; i_a1 = 4'd13; i_b1 = 4'd4;
    do_reset();
    ack_log.delete();
    repeat (16) begin
      step();
      if (o_ack0) begin i_a0 = W'($urandom); i_b0 = W'($urandom); end
      if (o_rvalid1) chk("t3_div", {27'd0, o_dz, o_result}, 32'd3);
    end
    chk("t3_ngrants", ack_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("t3_order", ack_log[i], i % 2);
    i_req0 = 0; i_req1 = 0;
    repeat (4) step();

    // 4: divide by zero, then wrapping subtract
    one_op(1, 2'b11, 4'd7, 4'd0, waited);
    chk("t4_dz", {27'd0, o_dz, o_result}, 32'h10);
    repeat (2) step();
    one_op(1, 2'b01, 4'd3, 4'd5, waited);
    chk("t4_sub", {27'd0, o_dz, o_result}, 32'd14);
    repeat (2) step();

    // 5: reset during EXEC
    i_req0 = 1; i_op0 = 2'b10; i_a0 = 4'd3; i_b0 = 4'd5;
    step();
    chk("t5_ack", {31'd0, o_ack0}, 32'd1);
    i_req0 = 0;
    #2 i_reset_n = 0;
    #1 chk("t5_out", {24'd0, o_ack0, o_ack1, o_rvalid0, o_rvalid1, o_busy, o_owner, o_dz, |o_result}, 32'd0);
    step();
    i_req0 = 1; i_op0 = 2'b00; i_a0 = 4'd1; i_b0 = 4'd1;
    i_req1 = 1; i_op1 = 2'b00; i_a1 = 4'd2; i_b1 = 4'd2;
    @(negedge i_clk) i_reset_n = 1;
    step();
    chk("t5_first_owner", {30'd0, o_ack1, o_ack0}, 32'd1);
    i_req0 = 0; i_req1 = 0;
    repeat (5) step();

    // 6: random traffic, requesters hold until ack then re-request or drop
    g0 = ngrant; guard = 0;
    while (ngrant < g0 + 1000 && guard < 20000) begin
      step(); guard++;
      if (ea0) begin
        i_req0 = $urandom_range(0, 1);
        i_op0 = 2'($urandom); i_a0 = W'($urandom); i_b0 = W'($urandom);
      end else if (!i_req0 && $urandom_range(0, 3) == 0) begin
        i_req0 = 1; i_op0 = 2'($urandom); i_a0 = W'($urandom); i_b0 = W'($urandom);
      end
      if (ea1) begin
        i_req1 = $urandom_range(0, 1);
        i_op1 = 2'($urandom); i_a1 = W'($urandom); i_b1 = W'($urandom);
      end else if (!i_req1 && $urandom_range(0, 3) == 0) begin
        i_req1 = 1; i_op1 = 2'($urandom); i_a1 = W'($urandom); i_b1 = W'($urandom);
      end
    end
    chk("t6_budget", {31'd0, guard < 20000}, 32'd1);
    i_req0 = 0; i_req1 = 0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
